// File: rtl/lsu_pkg.sv
// Shared LSU types and RV32I load/store decode helpers.
package lsu_pkg;

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [2:0] lsu_size(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic lsu_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // True when the access spills past the end of its word.
  function automatic logic lsu_cross(input logic [1:0] off, input logic [1:0] sz);
    return ({2'b00, off} + {1'b0, lsu_size(sz)}) > 4'd4;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: store mask/shift over a two-word window, load merge and extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rd0,
  input  logic [31:0] i_rd1,
  output logic [7:0]  o_mask,
  output logic [63:0] o_sdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_nmask;
  logic [4:0]  w_sh;
  logic [31:0] w_merged;

  assign w_sh = {i_off, 3'b000};

  always_comb begin
    w_nmask = 8'h0F;
    unique case (i_funct3[1:0])
      2'b00:   w_nmask = 8'h01;
      2'b01:   w_nmask = 8'h03;
      default: w_nmask = 8'h0F;
    endcase
  end

  assign o_mask   = w_nmask << i_off;
  assign o_sdata  = {32'h0, i_wdata} << w_sh;
  assign w_merged = 32'({i_rd1, i_rd0} >> w_sh);

  // funct3[2] set selects zero extension (LBU/LHU).
  always_comb begin
    o_ldata = w_merged;
    unique case (i_funct3[1:0])
      2'b00:   o_ldata = {{24{~i_funct3[2] & w_merged[7]}}, w_merged[7:0]};
      2'b01:   o_ldata = {{16{~i_funct3[2] & w_merged[15]}}, w_merged[15:0]};
      default: o_ldata = w_merged;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator for a word-addressed, byte-strobed data RAM.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dAddr,
  output logic [31:0] dWdata,
  output logic [3:0]  wstrb,
  input  logic [31:0] dRdata
);

  lsu_state_e  r_state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rd0;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_req_err;
  logic        w_cross;
  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_rd0;
  logic [31:0] w_rd1;
  logic [31:0] w_ldata;
  logic [7:0]  w_mask;
  logic [63:0] w_sdata;

  assign w_req_err = !lsu_legal(req_we, req_funct3) ||
                     (!ALLOW_MISALIGNED && lsu_cross(req_addr[1:0], req_funct3[1:0]));
  assign w_cross   = lsu_cross(r_addr[1:0], r_f3[1:0]);
  assign w_w0      = {r_addr[31:2], 2'b00};
  assign w_w1      = w_w0 + 32'd4;

  assign req_ready = (r_state == StIdle);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

  lsu_lane_align u_align (
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_f3),
    .i_wdata  (r_wdata),
    .i_rd0    (w_rd0),
    .i_rd1    (w_rd1),
    .o_mask   (w_mask),
    .o_sdata  (w_sdata),
    .o_ldata  (w_ldata)
  );

  // RAM side decodes straight from state so an async reset drops wstrb at once.
  always_comb begin
    dAddr  = 32'h0;
    dWdata = 32'h0;
    wstrb  = 4'h0;
    w_rd0  = r_rd0;
    w_rd1  = 32'h0;
    unique case (r_state)
      StAcc0: begin
        dAddr = w_w0;
        w_rd0 = dRdata;
        if (r_we) begin
          wstrb  = w_mask[3:0];
          dWdata = w_sdata[31:0];
        end
      end
      StAcc1: begin
        dAddr = w_w1;
        w_rd1 = dRdata;
        if (r_we) begin
          wstrb  = w_mask[7:4];
          dWdata = w_sdata[63:32];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_we        <= 1'b0;
      r_f3        <= 3'b000;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_rd0       <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (w_req_err) begin
              r_state     <= StResp;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state <= StAcc0;
            end
          end
        end
        StAcc0: begin
          r_rd0 <= dRdata;
          if (w_cross) begin
            r_state <= StAcc1;
          end else begin
            r_state     <= StResp;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_we ? 32'h0 : w_ldata;
          end
        end
        StAcc1: begin
          r_state     <= StResp;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_we ? 32'h0 : w_ldata;
        end
        StResp: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench: lsu_mem_master against a 128-word byte-strobed RAM model.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, dAddr, dWdata, dRdata;
  logic [3:0]  wstrb;

  logic        rdy2, rv2, err2;
  logic [31:0] rd2, addr2, wd2;
  logic [3:0]  strb2;

  logic [31:0] mem [128];
  logic [6:0]  ram_idx;

  int total = 0;
  int bad   = 0;

  logic [31:0] cap_addr [8];
  logic [3:0]  cap_strb [8];
  logic [31:0] cap_wd   [8];
  logic        c2_rv    [8];
  logic        c2_err   [8];
  logic        c2_rdy   [8];
  logic [31:0] c2_rd    [8];
  logic [31:0] c2_addr  [8];
  logic [31:0] c2_wd    [8];
  logic [3:0]  c2_strb  [8];

  always #5 clk = ~clk;

  lsu_mem_master u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dAddr      (dAddr),
    .dWdata     (dWdata),
    .wstrb      (wstrb),
    .dRdata     (dRdata)
  );

  lsu_mem_master #(.ALLOW_MISALIGNED(1'b0)) u_dut_nomis (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (rdy2),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rv2),
    .rsp_rdata  (rd2),
    .rsp_err    (err2),
    .dAddr      (addr2),
    .dWdata     (wd2),
    .wstrb      (strb2),
    .dRdata     (32'h0)
  );

  assign ram_idx = 7'((dAddr >> 2) & 32'h7F);
  assign dRdata  = mem[ram_idx];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) mem[ram_idx][8*b +: 8] <= dWdata[8*b +: 8];
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request from IDLE; lat = cycles from accept to rsp_valid (99 on timeout).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    lat = 99;
    rd  = 32'hBADBAD00;
    er  = 1'b1;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      req_valid   = 1'b0;
      cap_addr[c] = dAddr;
      cap_strb[c] = wstrb;
      cap_wd[c]   = dWdata;
      c2_rv[c]    = rv2;
      c2_err[c]   = err2;
      c2_rdy[c]   = rdy2;
      c2_rd[c]    = rd2;
      c2_addr[c]  = addr2;
      c2_wd[c]    = wd2;
      c2_strb[c]  = strb2;
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [5:0]  rdy_pat, rv_pat;
    logic [31:0] bb_rd [6];
    int          seen;

    for (int i = 0; i < 128; i++) mem[i] = 32'h0;

    vt[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h8765_4321, 32'h0000_0000, 1'b0, 2};
    vt[1]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h8765_4321, 1'b0, 2};
    vt[2]  = '{1'b1, 3'b000, 32'h0000_0013, 32'h1234_56AB, 32'h0000_0000, 1'b0, 2};
    vt[3]  = '{1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FFAB, 1'b0, 2};
    vt[4]  = '{1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_00AB, 1'b0, 2};
    vt[5]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hAB65_4321, 1'b0, 2};
    vt[6]  = '{1'b1, 3'b010, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3};
    vt[7]  = '{1'b0, 3'b010, 32'h0000_0022, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
    vt[8]  = '{1'b0, 3'b001, 32'h0000_0023, 32'h0,         32'hFFFF_ADBE, 1'b0, 3};
    vt[9]  = '{1'b0, 3'b101, 32'h0000_0021, 32'h0,         32'h0000_EF00, 1'b0, 2};
    vt[10] = '{1'b1, 3'b001, 32'h0000_0026, 32'h0000_8001, 32'h0000_0000, 1'b0, 2};
    vt[11] = '{1'b0, 3'b001, 32'h0000_0026, 32'h0,         32'hFFFF_8001, 1'b0, 2};
    vt[12] = '{1'b0, 3'b000, 32'h0000_0025, 32'h0,         32'hFFFF_FFDE, 1'b0, 2};
    vt[13] = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 1};
    vt[14] = '{1'b1, 3'b100, 32'h0000_0010, 32'h1111_1111, 32'h0000_0000, 1'b1, 1};
    vt[15] = '{1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0000_0000, 1'b0, 3};
    vt[16] = '{1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,         32'h1122_3344, 1'b0, 3};
    vt[17] = '{1'b0, 3'b101, 32'h0000_0000, 32'h0,         32'h0000_1122, 1'b0, 2};

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err",   32'(rsp_err), 32'h0);
    chk("reset_dAddr",     dAddr, 32'h0);
    chk("reset_dWdata",    dWdata, 32'h0);
    chk("reset_wstrb",     32'(wstrb), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, lat, rd, er);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vt[i].err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
    end

    // Aligned word store: single access, full strobe.
    do_req(1'b1, 3'b010, 32'h10, 32'h8765_4321, lat, rd, er);
    chk("sw_al_dAddr", cap_addr[1], 32'h10);
    chk("sw_al_wstrb", 32'(cap_strb[1]), 32'hF);
    chk("sw_al_dWdata", cap_wd[1], 32'h8765_4321);
    chk("sw_al_resp_wstrb", 32'(cap_strb[2]), 32'h0);

    // Crossing word store: two accesses with split strobes.
    do_req(1'b1, 3'b010, 32'h22, 32'hDEAD_BEEF, lat, rd, er);
    chk("sw_x_acc0_dAddr",  cap_addr[1], 32'h20);
    chk("sw_x_acc0_wstrb",  32'(cap_strb[1]), 32'hC);
    chk("sw_x_acc0_dWdata", cap_wd[1], 32'hBEEF_0000);
    chk("sw_x_acc1_dAddr",  cap_addr[2], 32'h24);
    chk("sw_x_acc1_wstrb",  32'(cap_strb[2]), 32'h3);
    chk("sw_x_acc1_dWdata", cap_wd[2], 32'h0000_DEAD);
    chk("sw_x_resp_wstrb",  32'(cap_strb[3]), 32'h0);
    chk("sw_x_resp_dAddr",  cap_addr[3], 32'h0);

    // Illegal funct3 load never strobes the RAM.
    do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er);
    chk("ill_wstrb", 32'(cap_strb[1]), 32'h0);
    chk("ill_dAddr", cap_addr[1], 32'h0);

    // No-misalign instance rejects a crossing load after one cycle.
    do_req(1'b0, 3'b010, 32'h22, 32'h0, lat, rd, er);
    chk("nomis_main_rdata", rd, 32'hDEAD_BEEF);
    chk("nomis_rsp_valid",  32'(c2_rv[1]), 32'h1);
    chk("nomis_rsp_err",    32'(c2_err[1]), 32'h1);
    chk("nomis_rsp_rdata",  c2_rd[1], 32'h0);
    chk("nomis_wstrb",      32'(c2_strb[1]), 32'h0);
    chk("nomis_dAddr",      c2_addr[1], 32'h0);
    chk("nomis_dWdata",     c2_wd[1], 32'h0);
    chk("nomis_ready_busy", 32'(c2_rdy[1]), 32'h0);
    chk("nomis_ready_idle", 32'(c2_rdy[2]), 32'h1);

    // Back-to-back: req_valid held, second accept only on the IDLE cycle after RESP.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    for (int c = 0; c < 6; c++) begin
      rdy_pat[c] = req_ready;
      rv_pat[c]  = rsp_valid;
      bb_rd[c]   = rsp_rdata;
      if (c == 4) req_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_ready_pattern", 32'(rdy_pat), 32'(6'b001001));
    chk("b2b_rsp_pattern",   32'(rv_pat),  32'(6'b100100));
    chk("b2b_rdata_first",   bb_rd[2], 32'h8765_4321);
    chk("b2b_rdata_second",  bb_rd[5], 32'h8765_4321);

    // Reset during ACC1 of a crossing store.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h23;
    req_wdata  = 32'h5566_7788;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_acc0_wstrb", 32'(wstrb), 32'h8);
    @(negedge clk);
    chk("rst_acc1_wstrb", 32'(wstrb), 32'h7);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wstrb_now",  32'(wstrb), 32'h0);
    chk("rst_dAddr_now",  dAddr, 32'h0);
    chk("rst_ready_now",  32'(req_ready), 32'h1);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rst_no_response", 32'(seen), 32'h0);
    chk("rst_word24_kept", mem[9], 32'h8001_DEAD);
    rst_n = 1'b1;

    do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er);
    chk("post_rst_rdata",   rd, 32'h88EF_0000);
    chk("post_rst_latency", 32'(lat), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
